alu_result_stage: RTL and testbench



---
 rtl/alu_stage_pkg.sv | 33 +++
 rtl/alu_result_stage_if.sv | 33 +++
 rtl/result_fifo.sv | 72 +++++++
 rtl/alu_result_stage.sv | 95 +++++++++
 tb/tb_alu_result_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_stage_pkg
// Types shared by the ALU output capture stages.
//   alu_stage_state_t : control FSM state of a capture stage (IDLE / SETTLE)
//   alu_result_t      : one captured result, data plus zero/negative flags
//   make_result()     : builds an alu_result_t from a raw mux word
// ----------------------------------------------------------------------------
package alu_stage_pkg;

    localparam int ALU_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } alu_stage_state_t;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             zero;
        logic             neg;
    } alu_result_t;

    // Flags are derived once, when the word is captured, so the FIFO output
    // path is pure storage with no arithmetic behind it.
    function automatic alu_result_t make_result(input logic [ALU_W-1:0] d);
        alu_result_t r;
        r.data = d;
        r.zero = (d == '0);
        r.neg  = d[ALU_W-1];
        return r;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ----------------------------------------------------------------------------
// alu_result_stage_if
// Request and result handshakes of the ALU result capture stage.
//   in_valid / in_ready : request from issuing control (mux will settle)
//   mux_out             : raw 16-bit mux word, sampled at the capture edge
//   out_valid/out_ready : FIFO head handshake towards the consumer
//   out_data/zero/neg   : FIFO head contents
//   busy                : stage is waiting for the mux to settle
// master = issuing control + consumer side, slave = the capture stage.
// ----------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mux_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             busy;

    modport master (
        output in_valid, mux_out, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, busy
    );

    modport slave (
        input  in_valid, mux_out, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, busy
    );
endinterface

// File: rtl/result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
// Small circular-buffer FIFO of ALU results.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_push_data at the tail
//   i_pop       : drop the head entry (ignored while empty)
//   o_head      : head entry, all zeros while empty
//   o_full      : count == DEPTH
//   o_empty     : count == 0
//   o_count     : number of stored entries
// The writer is expected to reserve space before pushing; there is no
// overflow protection here.
// ----------------------------------------------------------------------------
module result_fifo
    import alu_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = alu_result_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  T                             i_push_data,
    input  logic                         i_pop,
    output T                             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W = $clog2(DEPTH+1);

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == COUNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? T'('0) : r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage is reset too, so a stale word can never reach o_head;
    // with DEPTH <= 4 this costs only a handful of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            // Simultaneous push and pop leaves the count unchanged.
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
// Capture stage behind the 16-bit operand/result mux. A request is accepted
// only when the result FIFO has a free entry; the stage then waits
// SETTLE_CYC edges for the mux to settle, samples it with its zero/negative
// flags, and queues it for the consumer.
//   clkpos : single clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts a pending capture)
//   bus    : request + result handshakes (see alu_result_stage_if)
// ----------------------------------------------------------------------------
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH      = ALU_W,
    parameter int SETTLE_CYC = 2,
    parameter int DEPTH      = 2
) (
    input  logic              clkpos,
    input  logic              rst_n,
    alu_result_stage_if.slave bus
);
    localparam int CNT_W   = 4;
    localparam int COUNT_W = $clog2(DEPTH+1);

    alu_stage_state_t   r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [COUNT_W-1:0] w_count;
    alu_result_t        w_push_data;
    alu_result_t        w_head;

    // Ready is held low during reset so nothing upstream sees a handshake
    // complete while the stage is being cleared.
    assign bus.in_ready = (r_state == IDLE) && !w_full && rst_n;
    assign bus.busy     = (r_state == SETTLE);

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_push      = (r_state == SETTLE) && (r_cnt == '0);
    assign w_pop       = !w_empty && bus.out_ready;
    assign w_push_data = make_result(bus.mux_out);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= CNT_W'(SETTLE_CYC - 1);
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Space was reserved at acceptance and pops only free more, so the
    // capture push needs no full check.
    result_fifo #(
        .DEPTH (DEPTH),
        .T     (alu_result_t)
    ) u_fifo (
        .clk         (clkpos),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign bus.out_valid = (w_count != '0);
    assign bus.out_data  = w_head.data;
    assign bus.out_zero  = w_head.zero;
    assign bus.out_neg   = w_head.neg;

endmodule

// File: tb/tb_alu_result_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_result_stage
// Two stages (SETTLE_CYC = 2 and 1) driven by the same stimulus. A queue
// model per stage predicts ready/valid/head every cycle.
// ----------------------------------------------------------------------------
module tb_alu_result_stage;
    import alu_stage_pkg::*;

    localparam int DEPTH = 2;
    localparam int NI    = 2;

    logic clkpos = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clkpos = ~clkpos;

    alu_result_stage_if #(.WIDTH(16)) bus0 ();
    alu_result_stage_if #(.WIDTH(16)) bus1 ();

    alu_result_stage #(.WIDTH(16), .SETTLE_CYC(2), .DEPTH(DEPTH)) dut0 (
        .clkpos (clkpos),
        .rst_n  (rst_n),
        .bus    (bus0.slave)
    );

    alu_result_stage #(.WIDTH(16), .SETTLE_CYC(1), .DEPTH(DEPTH)) dut1 (
        .clkpos (clkpos),
        .rst_n  (rst_n),
        .bus    (bus1.slave)
    );

    // Observed outputs, indexed by stage.
    logic        o_rdy  [NI];
    logic        o_val  [NI];
    logic [15:0] o_data [NI];
    logic        o_zero [NI];
    logic        o_neg  [NI];
    logic        o_busy [NI];
    logic [1:0]  o_cnt  [NI];

    assign o_rdy[0]  = bus0.in_ready;   assign o_rdy[1]  = bus1.in_ready;
    assign o_val[0]  = bus0.out_valid;  assign o_val[1]  = bus1.out_valid;
    assign o_data[0] = bus0.out_data;   assign o_data[1] = bus1.out_data;
    assign o_zero[0] = bus0.out_zero;   assign o_zero[1] = bus1.out_zero;
    assign o_neg[0]  = bus0.out_neg;    assign o_neg[1]  = bus1.out_neg;
    assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
    assign o_cnt[0]  = dut0.w_count;    assign o_cnt[1]  = dut1.w_count;

    // Model: queued results and remaining settle edges (-1 = not settling).
    logic [15:0] mq [NI][$];
    int          mp [NI];
    int          ms [NI] = '{2, 1};

    int total = 0;
    int bad   = 0;
    int ovf   = 0;

    always @(posedge clkpos) begin
        if (rst_n && dut0.w_push && dut0.w_full) ovf++;
        if (rst_n && dut1.w_push && dut1.w_full) ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int i);
        return rst_n && (mp[i] < 0) && (mq[i].size() < DEPTH);
    endfunction

    task automatic compare_all(input int i);
        logic        ev;
        logic [15:0] ed;
        ev = (mq[i].size() != 0);
        ed = ev ? mq[i][0] : 16'h0000;
        check($sformatf("u%0d.in_ready", i),  32'(o_rdy[i]),  32'(exp_ready(i)));
        check($sformatf("u%0d.out_valid", i), 32'(o_val[i]),  32'(ev));
        check($sformatf("u%0d.out_data", i),  32'(o_data[i]), 32'(ed));
        check($sformatf("u%0d.out_zero", i),  32'(o_zero[i]), 32'(ev && (ed == 16'h0000)));
        check($sformatf("u%0d.out_neg", i),   32'(o_neg[i]),  32'(ev && ed[15]));
        check($sformatf("u%0d.busy", i),      32'(o_busy[i]), 32'(mp[i] >= 0));
        check($sformatf("u%0d.count", i),     32'(o_cnt[i]),  32'(mq[i].size()));
    endtask

    task automatic model_step(input int i, input logic acc, input logic [15:0] d, input logic r);
        if (r && mq[i].size() > 0) void'(mq[i].pop_front());
        if (mp[i] == 0) begin
            mq[i].push_back(d);
            mp[i] = -1;
        end else if (mp[i] > 0) begin
            mp[i]--;
        end
        if (acc) mp[i] = ms[i] - 1;
    endtask

    // Entered and left at posedge+1: drive, check at negedge, step at posedge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        logic acc [NI];
        bus0.in_valid = v;  bus1.in_valid = v;
        bus0.mux_out  = d;  bus1.mux_out  = d;
        bus0.out_ready = r; bus1.out_ready = r;
        @(negedge clkpos);
        for (int i = 0; i < NI; i++) begin
            compare_all(i);
            acc[i] = v && exp_ready(i);
        end
        @(posedge clkpos);
        for (int i = 0; i < NI; i++) model_step(i, acc[i], d, r);
        #1;
    endtask

    task automatic hold(input logic v, input logic [15:0] d, input logic r, input int n);
        for (int k = 0; k < n; k++) cycle(v, d, r);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            mp[i] = -1;
        end
        #1;
        for (int i = 0; i < NI; i++) compare_all(i);
        @(posedge clkpos);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus0.mux_out  = '0;   bus1.mux_out  = '0;
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
        mp[0] = -1;
        mp[1] = -1;

        reset_mid();

        // Single request, then pop.
        hold(1'b1, 16'h1234, 1'b0, 1);
        hold(1'b0, 16'h1234, 1'b0, 4);
        hold(1'b0, 16'h0000, 1'b1, 1);
        hold(1'b0, 16'h0000, 1'b0, 2);

        // Flag captures.
        hold(1'b1, 16'h0000, 1'b0, 1);
        hold(1'b0, 16'h0000, 1'b0, 3);
        hold(1'b0, 16'h0000, 1'b1, 2);
        hold(1'b1, 16'h8001, 1'b0, 1);
        hold(1'b0, 16'h8001, 1'b0, 3);
        hold(1'b0, 16'h0000, 1'b1, 2);

        // Fill the FIFO with the consumer stalled, then free one entry.
        hold(1'b1, 16'hAAAA, 1'b0, 3);
        hold(1'b1, 16'h5555, 1'b0, 3);
        hold(1'b1, 16'h5555, 1'b0, 3);
        hold(1'b1, 16'hCCCC, 1'b1, 1);
        hold(1'b1, 16'hCCCC, 1'b0, 3);
        hold(1'b0, 16'h0000, 1'b1, 6);

        // One entry parked, then pops lined up with captures; 10 requests.
        hold(1'b1, 16'h0F00, 1'b0, 1);
        hold(1'b0, 16'h0F00, 1'b0, 3);
        for (int k = 0; k < 10; k++) begin
            d = 16'h0100 + 16'(k);
            hold(1'b1, d, 1'b0, 1);
            hold(1'b0, d, 1'b0, 1);
            hold(1'b0, d, 1'b1, 1);
        end
        hold(1'b0, 16'h0000, 1'b1, 4);

        // Reset one cycle after acceptance: the pending capture is lost.
        hold(1'b1, 16'hDEAD, 1'b0, 1);
        reset_mid();
        hold(1'b0, 16'hDEAD, 1'b1, 5);

        // Back-to-back requests with a free-running consumer.
        for (int k = 0; k < 16; k++) cycle(1'b1, 16'h0040 + 16'(k), 1'b1);
        hold(1'b0, 16'h0000, 1'b1, 4);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(3))
                0:       d = 16'h0000;
                1:       d = 16'h8000 | 16'($urandom);
                default: d = 16'($urandom);
            endcase
            if ($urandom_range(199) == 0) reset_mid();
            else cycle(1'($urandom), d, 1'($urandom_range(3) != 0));
        end
        hold(1'b0, 16'h0000, 1'b1, 6);

        check("no_push_when_full", 32'(ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
